// File: rtl/transpose_read_sequencer.sv
// transpose_read_sequencer: walks the matrix in transposed order and streams words through a 3-entry FIFO
module transpose_read_sequencer #(
  parameter int MATRIX_DIM = 8,
  parameter int COL_WIDTH = 8,
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = $clog2(MATRIX_DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                mem_read_en,
  output logic [ADDR_LEN-1:0] mem_read_row,
  output logic [ADDR_LEN-1:0] mem_read_col,
  input  logic [WORD_LEN-1:0] mem_data,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);
  localparam int COLS_PER_WORD = WORD_LEN / COL_WIDTH;
  localparam int WORDS_PER_ROW = MATRIX_DIM / COLS_PER_WORD;
  localparam logic [ADDR_LEN-1:0] STRIDE = ADDR_LEN'(COLS_PER_WORD);
  localparam logic [ADDR_LEN-1:0] ROW_MAX = ADDR_LEN'((WORDS_PER_ROW - 1) * COLS_PER_WORD);
  localparam logic [ADDR_LEN-1:0] COL_MAX = ADDR_LEN'(MATRIX_DIM - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_LEN-1:0] row, col;
  logic inflight, inflight_last;
  logic [1:0] count, wr_idx;
  logic [WORD_LEN:0] q [3];
  logic row_end, last_rd, push, pop;
  assign row_end = row == ROW_MAX;
  assign last_rd = row_end && col == COL_MAX;
  assign push = inflight;
  assign pop = out_valid && out_ready;
  assign wr_idx = count - {1'b0, pop};
  assign busy = state != IDLE;
  assign mem_read_row = row;
  assign mem_read_col = col;
  assign out_valid = count != 2'd0;
  assign out_data = out_valid ? q[0][WORD_LEN-1:0] : '0;
  assign out_last = out_valid && q[0][WORD_LEN];
  // done is high in the first IDLE cycle; a start there still belongs to the finished pass
  always_comb begin
    mem_read_en = state == RUN && (3'(count) + 3'(inflight)) < 3'd3;
    state_nx = state;
    state_nx = state == IDLE ? (start && !done ? RUN : IDLE)
             : state == RUN  ? (mem_read_en && last_rd ? DRAIN : RUN)
             : (pop && out_last ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      count <= 2'd0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= mem_read_en;
      inflight_last <= mem_read_en && last_rd;
      done <= pop && out_last;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (mem_read_en) begin
        row <= row_end ? '0 : row + STRIDE;
        col <= row_end ? col + ADDR_LEN'(1) : col;
      end
    end
  end
  // head is always q[0]; the tail slot follows the count after any pop
  always_ff @(posedge clk) begin
    if (pop) begin
      q[0] <= q[1];
      q[1] <= q[2];
    end
    for (int i = 0; i < 3; i++)
      if (push && wr_idx == 2'(i)) q[i] <= {inflight_last, mem_data};
  end
endmodule

// File: tb/tb_transpose_read_sequencer.sv
// tb_transpose_read_sequencer: randomized bench with a transaction-level reference model
module tb_transpose_read_sequencer;
  localparam int N = 8, CPW = 4, WPR = N / CPW, TW = N * WPR;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic busy, done, mem_read_en, out_valid, out_last;
  logic [2:0] mem_read_row, mem_read_col;
  logic [31:0] mem_data, out_data;
  logic [31:0] memarr [64];
  int vectors = 0, miscompares = 0;
  bit m_busy, m_done, exp_en, exp_valid, hs, ob, od, pv, pr;
  logic [31:0] pd;
  int issued, popped, prev_issued, cyc, first_en, last_en, first_v, last_v, done_cyc, n_en, n_done;

  transpose_read_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_read_en(mem_read_en), .mem_read_row(mem_read_row), .mem_read_col(mem_read_col),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_read_en ? memarr[{mem_read_row, mem_read_col}] : $urandom;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  function automatic logic [5:0] addr_of(input int k);
    return {3'((k % WPR) * CPW), 3'(k / WPR)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {busy, done, mem_read_en, mem_read_row, mem_read_col, out_valid, out_last, out_data}, '0);
      m_busy = 0; m_done = 0; issued = 0; popped = 0; prev_issued = 0; pv = 0;
    end else begin
      ob = m_busy; od = m_done;
      cyc++;
      exp_en = m_busy && issued < TW && issued - popped < 3;
      exp_valid = prev_issued - popped > 0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("read_en", mem_read_en, exp_en);
      chk("out_valid", out_valid, exp_valid);
      chk("out_last", out_last, exp_valid && popped == TW - 1);
      if (mem_read_en) begin
        chk("read_addr", {mem_read_row, mem_read_col}, addr_of(issued));
        n_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (pv && !pr) chk("stall_hold", {out_valid, out_data}, {1'b1, pd});
      if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      hs = out_valid && out_ready;
      if (hs) chk("out_data", out_data, memarr[addr_of(popped)]);
      m_done = hs && popped == TW - 1;
      if (hs) begin
        popped++;
        if (popped == TW) m_busy = 0;
      end
      prev_issued = issued;
      if (exp_en) issued++;
      pv = out_valid; pr = out_ready; pd = out_data;
      if (start && !ob && !od) begin
        m_busy = 1; issued = 0; popped = 0; prev_issued = 0; cyc = 0;
        first_en = -1; last_en = -1; first_v = -1; last_v = -1; done_cyc = -1; n_en = 0; n_done = 0;
      end
    end
  end

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic check_full_pass(input string tag);
    chk({tag, "_first_en"}, first_en, 1);
    chk({tag, "_last_en"}, last_en, 16);
    chk({tag, "_n_en"}, n_en, 16);
    chk({tag, "_first_valid"}, first_v, 3);
    chk({tag, "_last_valid"}, last_v, 18);
    chk({tag, "_done_cycle"}, done_cyc, 19);
    chk({tag, "_n_done"}, n_done, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memarr[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    pulse_start();
    repeat (21) @(posedge clk);
    #1 check_full_pass("full");
    out_ready = 0;
    pulse_start();
    repeat (8) @(posedge clk);
    #1 chk("stall_n_en", n_en, 3);
    chk("stall_last_en", last_en, 3);
    pulse_start();
    out_ready = 1;
    repeat (40) @(posedge clk);
    #1 chk("stall_n_en_total", n_en, 16);
    chk("stall_n_done", n_done, 1);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom);
      start = done || $urandom_range(0, 24) == 0;
    end
    start = 0;
    out_ready = 1;
    repeat (40) @(posedge clk);
    #1 pulse_start();
    repeat (7) @(posedge clk);
    #2 chk("pre_reset_busy", busy, 1);
    rst = 1;
    #1 chk("async_reset", {busy, done, mem_read_en, mem_read_row, mem_read_col, out_valid, out_last, out_data}, '0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 pulse_start();
    repeat (21) @(posedge clk);
    #1 check_full_pass("after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
